// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and instruction memory.
// Data is valid in the same cycle that ack is high.
interface inst_fetch_if #(
  parameter int unsigned AddrW = 32
) ();
  logic             req;
  logic [AddrW-1:0] addr;
  logic             ack;
  logic [31:0]      data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: holds the PC, runs the req/ack handshake to instruction memory, latches the
// fetched word, splits it into fields and computes the next PC when the instruction is consumed.
module inst_fetch #(
  parameter int unsigned      AddrW   = 32,
  parameter logic [AddrW-1:0] ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  inst_fetch_if.master     imem,
  input  logic             stall_i,
  input  logic [1:0]       pc_src_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      data_ext_i,
  input  logic [31:0]      reg_target_i,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic [AddrW-1:0] pc_o,
  output logic [AddrW-1:0] pc_plus4_o,
  output logic [5:0]       opcode_o,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [5:0]       funct_o,
  output logic [15:0]      imm_o,
  output logic             fault_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StErr} state_e;

  state_e           state_q;
  logic [AddrW-1:0] pc_q;
  logic [31:0]      instr_q;
  logic             valid_q;
  logic             fault_q;
  logic             req_q;

  logic [AddrW-1:0] pc_plus4;
  logic [AddrW-1:0] next_pc;
  logic             misaligned;

  assign pc_plus4 = pc_q + AddrW'(4);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src_i)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = branch_taken_i ? pc_plus4 + AddrW'(data_ext_i << 2) : pc_plus4;
      2'b10: next_pc = {pc_plus4[AddrW-1:28], instr_q[25:0], 2'b00};
      2'b11: next_pc = AddrW'(reg_target_i);
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

  // Outputs req/valid are registered so they depend on state only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= ResetPc;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          state_q <= StReq;
        end
        StReq: begin
          if (imem.ack) begin
            instr_q <= imem.data;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (!stall_i) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              fault_q <= 1'b1;
              state_q <= StErr;
            end else begin
              pc_q    <= next_pc;
              req_q   <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
          state_q <= StErr;
        end
      endcase
    end
  end

  assign imem.req      = req_q;
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign fault_o       = fault_q;

  assign opcode_o = instr_q[31:26];
  assign rs_o     = instr_q[25:21];
  assign rt_o     = instr_q[20:16];
  assign rd_o     = instr_q[15:11];
  assign funct_o  = instr_q[5:0];
  assign imm_o    = instr_q[15:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: handshake, next-PC selection, stall, ack delay, fault and reset.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] data_ext;
  logic [31:0] reg_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        fault;

  int passed = 0;
  int total  = 0;

  inst_fetch_if #(.AddrW(32)) imem ();

  inst_fetch #(
    .AddrW  (32),
    .ResetPc(32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem          (imem.master),
    .stall_i       (stall),
    .pc_src_i      (pc_src),
    .branch_taken_i(branch_taken),
    .data_ext_i    (data_ext),
    .reg_target_i  (reg_target),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .opcode_o      (opcode),
    .rs_o          (rs),
    .rt_o          (rt),
    .rd_o          (rd),
    .funct_o       (funct),
    .imm_o         (imm),
    .fault_o       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, then acks it with the given word; ends in HOLD at a negedge.
  task automatic fetch(input string tag, input logic [31:0] word);
    int n = 0;
    while (imem.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'd0, imem.req}, 32'd1);
    imem.ack  = 1'b1;
    imem.data = word;
    @(negedge clk);
    imem.ack  = 1'b0;
    imem.data = 32'h0;
  endtask

  // Releases stall for exactly one edge with the given next-PC controls.
  task automatic consume(input logic [1:0] src, input logic bt, input logic [31:0] ext,
                         input logic [31:0] rtgt);
    stall        = 1'b0;
    pc_src       = src;
    branch_taken = bt;
    data_ext     = ext;
    reg_target   = rtgt;
    @(negedge clk);
    stall        = 1'b1;
    pc_src       = 2'b00;
    branch_taken = 1'b0;
    data_ext     = 32'h0;
    reg_target   = 32'h0;
  endtask

  initial begin
    rst_n        = 1'b0;
    stall        = 1'b1;
    pc_src       = 2'b00;
    branch_taken = 1'b0;
    data_ext     = 32'h0;
    reg_target   = 32'h0;
    imem.ack     = 1'b0;
    imem.data    = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, imem.req},    32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_fault", {31'd0, fault},       32'd0);
    chk("rst_imm",   {16'd0, imm},         32'h0);
    chk("rst_pc4",   pc_plus4,             32'h4);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req",  {31'd0, imem.req}, 32'd1);
    chk("first_addr", imem.addr,         32'h0);
    fetch("f0", 32'h2008_0005);
    chk("f0_instr",  instr,                32'h2008_0005);
    chk("f0_valid",  {31'd0, instr_valid}, 32'd1);
    chk("f0_imm",    {16'd0, imm},         32'h0005);
    chk("f0_rt",     {27'd0, rt},          32'd8);
    chk("f0_op",     {26'd0, opcode},      32'd8);
    chk("f0_hreq",   {31'd0, imem.req},    32'd0);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    chk("seq_addr",  imem.addr,            32'h4);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);

    // Register jump to an aligned target.
    fetch("f1", 32'h0000_0000);
    consume(2'b11, 1'b0, 32'h0, 32'h10);
    chk("rj_addr", imem.addr, 32'h10);

    fetch("f2", 32'h1000_FFFE);
    consume(2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0);
    chk("br_neg", imem.addr, 32'h0C);
    fetch("f3", 32'h0);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    chk("back_10", imem.addr, 32'h10);
    fetch("f4", 32'h1000_8000);
    consume(2'b01, 1'b1, 32'h0000_8000, 32'h0);
    chk("br_pos", imem.addr, 32'h0002_0014);
    fetch("f5", 32'h1000_0001);
    consume(2'b01, 1'b0, 32'h0000_0100, 32'h0);
    chk("br_not", imem.addr, 32'h0002_0018);

    // Stall for 5 cycles with noisy next-PC controls, which must be ignored.
    fetch("f6", 32'hDEAD_BEEF);
    pc_src     = 2'b11;
    reg_target = 32'h0000_0103;
    repeat (5) @(negedge clk);
    chk("st_instr", instr,                32'hDEAD_BEEF);
    chk("st_pc",    pc,                   32'h0002_0018);
    chk("st_valid", {31'd0, instr_valid}, 32'd1);
    chk("st_req",   {31'd0, imem.req},    32'd0);
    chk("st_fault", {31'd0, fault},       32'd0);
    chk("st_funct", {26'd0, funct},       32'h2F);
    chk("st_rd",    {27'd0, rd},          32'h17);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    chk("st_next", imem.addr,         32'h0002_001C);
    chk("st_nreq", {31'd0, imem.req}, 32'd1);

    // Ack withheld for 4 cycles.
    repeat (4) @(negedge clk);
    chk("wait_req",   {31'd0, imem.req},    32'd1);
    chk("wait_addr",  imem.addr,            32'h0002_001C);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    fetch("f7", 32'h1234_5678);
    chk("f7_instr", instr, 32'h1234_5678);

    consume(2'b11, 1'b0, 32'h0, 32'h4000_0000);
    fetch("f8", 32'h0800_0100);
    chk("j_pc4", pc_plus4, 32'h4000_0004);
    consume(2'b10, 1'b0, 32'h0, 32'h0);
    chk("j_addr", imem.addr, 32'h4000_0400);

    fetch("f9", 32'h0);
    consume(2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    fetch("f10", 32'h0);
    chk("wrap_pc4", pc_plus4, 32'h0);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    chk("wrap_next", imem.addr, 32'h0);

    fetch("f11", 32'h0);
    consume(2'b11, 1'b0, 32'h0, 32'h0000_0102);
    chk("err_fault", {31'd0, fault},       32'd1);
    chk("err_req",   {31'd0, imem.req},    32'd0);
    chk("err_valid", {31'd0, instr_valid}, 32'd0);
    chk("err_pc",    pc,                   32'h0);
    repeat (4) @(negedge clk);
    chk("err_stick", {31'd0, fault},    32'd1);
    chk("err_noreq", {31'd0, imem.req}, 32'd0);

    // Recover, then reset in the middle of a request with ack high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch("f12", 32'h2008_0005);
    consume(2'b00, 1'b0, 32'h0, 32'h0);
    chk("pre_addr", imem.addr, 32'h4);
    imem.ack  = 1'b1;
    imem.data = 32'hFFFF_FFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_instr", instr,                32'h0);
    chk("ar_pc",    pc,                   32'h0);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_req",   {31'd0, imem.req},    32'd0);
    @(negedge clk);
    chk("ar_ackign", instr, 32'h0);
    imem.ack  = 1'b0;
    imem.data = 32'h0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("rs_req",  {31'd0, imem.req}, 32'd1);
    chk("rs_addr", imem.addr,         32'h0);
    fetch("f13", 32'hCAFE_0001);
    chk("rs_instr", instr, 32'hCAFE_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
